// File: rtl/fwd_hazard_scheduler.sv
// fwd_hazard_scheduler: issue-stage scheduler for the operand-forwarding network.
// It tracks destination writes in flight across ForwardDepth stages (stage 0 =
// issued last cycle). For each operand it picks the youngest producer that can
// forward, or the register file when there is none. When the youngest producer's
// result is not yet forwardable, it holds in_ready low and inserts bubbles.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   pipe_en             downstream advance enable (0 freezes the tracker)
//   flush               synchronous invalidate of every in-flight entry
//   in_valid/in_ready   issue handshake
//   in_rs_a, in_rs_b    source operands
//   in_rd, in_rd_we     destination register and its write enable
//   in_lat              cycles from issue until the result is forwardable
//   fwd_a_sel/fwd_b_sel one-hot forward select (all-zero = register file)
//   stall               in_valid && hazard
//   stall_count         saturating count of stall cycles

// Per-operand pick: youngest matching entry, and whether it can forward yet.
module fwd_operand_pick #(
  parameter int ForwardDepth = 3,
  parameter int RegAddrWidth = 3,
  parameter int LatWidth     = 2
) (
  input  logic [ForwardDepth-1:0]                   vldPipe,
  input  logic [ForwardDepth-1:0][RegAddrWidth-1:0] rdPipe,
  input  logic [ForwardDepth-1:0][LatWidth-1:0]     latPipe,
  input  logic [RegAddrWidth-1:0]                   rs,
  output logic [ForwardDepth-1:0]                   sel,
  output logic                                      hazard
);
  logic found;

  // Scan from youngest to oldest. The first match decides the outcome, so an
  // older producer of the same register is never selected.
  always_comb begin
    sel    = '0;
    hazard = 1'b0;
    found  = 1'b0;
    for (int i = 0; i < ForwardDepth; i++) begin
      if (!found && vldPipe[i] && rdPipe[i] == rs) begin
        found = 1'b1;
        if (i + 1 >= int'(latPipe[i])) sel[i] = 1'b1;
        else                           hazard = 1'b1;
      end
    end
  end
endmodule

module fwd_hazard_scheduler #(
  parameter  int ForwardDepth  = 3,
  parameter  int RegisterCount = 8,
  parameter  int LatWidth      = $clog2(ForwardDepth + 1),
  localparam int RegAddrWidth  = $clog2(RegisterCount)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pipe_en,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [RegAddrWidth-1:0] in_rs_a,
  input  logic [RegAddrWidth-1:0] in_rs_b,
  input  logic [RegAddrWidth-1:0] in_rd,
  input  logic                    in_rd_we,
  input  logic [LatWidth-1:0]     in_lat,
  output logic [ForwardDepth-1:0] fwd_a_sel,
  output logic [ForwardDepth-1:0] fwd_b_sel,
  output logic                    stall,
  output logic [15:0]             stall_count
);
  localparam int NumOps = 2;

  logic [ForwardDepth-1:0]                   vldPipe;
  logic [ForwardDepth-1:0][RegAddrWidth-1:0] rdPipe;
  logic [ForwardDepth-1:0][LatWidth-1:0]     latPipe;

  logic [NumOps-1:0][RegAddrWidth-1:0] rsOp;
  logic [NumOps-1:0][ForwardDepth-1:0] selOp;
  logic [NumOps-1:0]                   hazOp;
  logic                                hazard;
  logic [LatWidth-1:0]                 latSat;

  assign rsOp = {in_rs_b, in_rs_a};

  for (genvar g = 0; g < NumOps; g++) begin : gOp
    fwd_operand_pick #(
      .ForwardDepth(ForwardDepth),
      .RegAddrWidth(RegAddrWidth),
      .LatWidth    (LatWidth)
    ) uPick (
      .vldPipe(vldPipe),
      .rdPipe (rdPipe),
      .latPipe(latPipe),
      .rs     (rsOp[g]),
      .sel    (selOp[g]),
      .hazard (hazOp[g])
    );
  end

  assign fwd_a_sel = selOp[0];
  assign fwd_b_sel = selOp[1];
  assign hazard    = |hazOp;
  assign stall     = in_valid && hazard;
  assign in_ready  = pipe_en && !hazard && !flush;

  // A latency of 0 behaves as 1. Anything beyond the depth can only forward
  // from the last stage.
  always_comb begin
    latSat = in_lat;
    if (in_lat == '0)                      latSat = LatWidth'(1);
    else if (int'(in_lat) > ForwardDepth)  latSat = LatWidth'(ForwardDepth);
  end

  // Only the valid bits need clearing on a flush; stale rd/lat fields are
  // ignored while their valid bit is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vldPipe <= '0;
      rdPipe  <= '0;
      latPipe <= '0;
    end else if (flush) begin
      vldPipe <= '0;
    end else if (pipe_en) begin
      for (int i = ForwardDepth - 1; i >= 1; i--) begin
        vldPipe[i] <= vldPipe[i-1];
        rdPipe[i]  <= rdPipe[i-1];
        latPipe[i] <= latPipe[i-1];
      end
      vldPipe[0] <= in_valid && in_ready && in_rd_we;
      rdPipe[0]  <= in_rd;
      latPipe[0] <= latSat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_count <= '0;
    else if (pipe_en && stall && !flush && stall_count != 16'hFFFF)
      stall_count <= stall_count + 16'd1;
  end
endmodule
